// File: rtl/conv_window_gen_pkg.sv
// Shared definitions for the 3x3 convolution window generator.
// Optional position outputs are controlled by macro CONV_WINDOW_POS_EN.
package conv_pkg;

    localparam int unsigned KERNEL_3 = 3;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN
    } state_t;

    function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
        return KERNEL_3 * r + c;
    endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bus of conv_window_gen.
// CONV_WINDOW_POS_EN adds win_col/win_row (and the image-size parameters they need).
interface conv_window_gen_if
    import conv_pkg::*;
#(
    parameter int DIN_WIDTH = 32
`ifdef CONV_WINDOW_POS_EN
    , parameter int IMAGE_WIDTH  = 32,
    parameter int IMAGE_HEIGHT = 32
`endif
) ();

    logic                                   valid_in;
    logic [DIN_WIDTH-1:0]                   data_in;
    logic [KERNEL_3*KERNEL_3*DIN_WIDTH-1:0] win_out;
    logic                                   valid_out;
    logic                                   frame_done;

`ifdef CONV_WINDOW_POS_EN
    logic [$clog2(IMAGE_WIDTH)-1:0]  win_col;
    logic [$clog2(IMAGE_HEIGHT)-1:0] win_row;

    modport master (
        output valid_in, data_in,
        input  win_out, valid_out, frame_done, win_col, win_row
    );

    modport slave (
        input  valid_in, data_in,
        output win_out, valid_out, frame_done, win_col, win_row
    );
`else
    modport master (
        output valid_in, data_in,
        input  win_out, valid_out, frame_done
    );

    modport slave (
        input  valid_in, data_in,
        output win_out, valid_out, frame_done
    );
`endif

endinterface

// File: rtl/conv_window_gen_row_delay.sv
// One image-row delay: circular RAM with a single read-before-write pointer.
// tap is the sample written DEPTH enabled cycles ago.
module row_delay #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tap
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr_q] <= din;
        end
    end

    assign tap = mem[ptr_q];

endmodule

// File: rtl/conv_window_gen.sv
// 3x3 stride-1 sliding window generator over a raster pixel stream.
// Macro CONV_WINDOW_POS_EN adds the window top-left coordinate outputs.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 32,
    parameter int IMAGE_HEIGHT = 32,
    parameter int DIN_WIDTH    = 32
) (
    input  logic             clk,
    input  logic             reset,
    conv_window_gen_if.slave bus
);

    localparam int unsigned CW = $clog2(IMAGE_WIDTH);
    localparam int unsigned RW = $clog2(IMAGE_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [DIN_WIDTH-1:0] tap1, tap2;

    logic [KERNEL_3*KERNEL_3-1:0][DIN_WIDTH-1:0] win_q, win_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    state_t        state_q, state_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic          col_last, row_last;
`ifdef CONV_WINDOW_POS_EN
    logic [CW-1:0] win_col_q, win_col_d;
    logic [RW-1:0] win_row_q, win_row_d;
`endif

    row_delay #(.DEPTH(IMAGE_WIDTH), .WIDTH(DIN_WIDTH)) u_row_delay1 (
        .clk   (clk),
        .reset (reset),
        .en    (bus.valid_in),
        .din   (bus.data_in),
        .tap   (tap1)
    );

    row_delay #(.DEPTH(IMAGE_WIDTH), .WIDTH(DIN_WIDTH)) u_row_delay2 (
        .clk   (clk),
        .reset (reset),
        .en    (bus.valid_in),
        .din   (tap1),
        .tap   (tap2)
    );

    always_comb begin
        win_d    = win_q;
        col_d    = col_q;
        row_d    = row_q;
        state_d  = state_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        col_last = (col_q == COL_LAST);
        row_last = (row_q == ROW_LAST);
`ifdef CONV_WINDOW_POS_EN
        win_col_d = win_col_q;
        win_row_d = win_row_q;
`endif
        if (bus.valid_in) begin
            for (int unsigned r = 0; r < KERNEL_3; r++) begin
                win_d[win_idx(r, 0)] = win_q[win_idx(r, 1)];
                win_d[win_idx(r, 1)] = win_q[win_idx(r, 2)];
            end
            win_d[win_idx(0, 2)] = tap2;
            win_d[win_idx(1, 2)] = tap1;
            win_d[win_idx(2, 2)] = bus.data_in;

            // Gating on the counters keeps stale delay data from a previous frame hidden.
            valid_d = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
            done_d  = col_last && row_last;
`ifdef CONV_WINDOW_POS_EN
            if (valid_d) begin
                win_col_d = col_q - COL_TWO;
                win_row_d = row_q - ROW_TWO;
            end
`endif
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            case (state_q)
                IDLE:    state_d = FILL;
                FILL:    if (col_last && row_q == ROW_ONE) state_d = RUN;
                RUN:     if (col_last && row_last) state_d = FILL;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            state_q <= IDLE;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef CONV_WINDOW_POS_EN
            win_col_q <= '0;
            win_row_q <= '0;
`endif
        end else begin
            win_q   <= win_d;
            col_q   <= col_d;
            row_q   <= row_d;
            state_q <= state_d;
            valid_q <= valid_d;
            done_q  <= done_d;
`ifdef CONV_WINDOW_POS_EN
            win_col_q <= win_col_d;
            win_row_q <= win_row_d;
`endif
        end
    end

    assign bus.win_out    = win_q;
    assign bus.valid_out  = valid_q;
    assign bus.frame_done = done_q;
`ifdef CONV_WINDOW_POS_EN
    assign bus.win_col    = win_col_q;
    assign bus.win_row    = win_row_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: a 4x4 instance for the corner cases and a
// default 32x32 instance for the ramp frame; position outputs checked under CONV_WINDOW_POS_EN.
module tb_conv_window_gen;

    localparam int DW = 32;
    localparam int WW = 9 * DW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_val(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [WW-1:0] pack9(input int unsigned e0, e1, e2, e3, e4, e5, e6, e7, e8);
        int unsigned e [9];
        logic [WW-1:0] v;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
        e[5] = e5; e[6] = e6; e[7] = e7; e[8] = e8;
        v = '0;
        for (int i = 0; i < 9; i++) v[DW*i +: DW] = DW'(e[i]);
        return v;
    endfunction

    // Pixel (r,c) of a frame is v0 + w*r + c; window with top-left (tr,tc).
    function automatic logic [WW-1:0] model_win(input int unsigned v0, w, tr, tc);
        logic [WW-1:0] v;
        v = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                v[DW*(3*r+c) +: DW] = DW'(v0 + w*(tr + r) + tc + c);
        return v;
    endfunction

    conv_window_gen_if #(
        .DIN_WIDTH(DW)
`ifdef CONV_WINDOW_POS_EN
        , .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4)
`endif
    ) bus_a ();

    conv_window_gen_if #(
        .DIN_WIDTH(DW)
`ifdef CONV_WINDOW_POS_EN
        , .IMAGE_WIDTH(32), .IMAGE_HEIGHT(32)
`endif
    ) bus_b ();

    conv_window_gen #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .DIN_WIDTH(DW)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    conv_window_gen #(.IMAGE_WIDTH(32), .IMAGE_HEIGHT(32), .DIN_WIDTH(DW)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    int unsigned cyc = 0;
    logic        acc_a = 1'b0;
    logic        vo_prev_a = 1'b0;
    logic        bubble_mode = 1'b0;
    logic [WW-1:0] wq_a [$];
    logic          fq_a [$];
    int unsigned   vc_a [$];
    logic [WW-1:0] wq_b [$];
    logic          fq_b [$];
    int unsigned   colq_b [$];
    int unsigned   rowq_b [$];

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        acc_a <= bus_a.valid_in & ~reset;
    end

    always @(negedge clk) begin
        check_val("a_fd_implies_vo", bus_a.frame_done & ~bus_a.valid_out, 0);
        if (bus_a.valid_out) begin
            check_val("a_vo_after_accept", acc_a, 1);
            if (bubble_mode) check_val("a_vo_not_consecutive", vo_prev_a, 0);
            wq_a.push_back(bus_a.win_out);
            fq_a.push_back(bus_a.frame_done);
            vc_a.push_back(cyc);
        end
        vo_prev_a <= bus_a.valid_out;
    end

    always @(negedge clk) begin
        if (bus_b.valid_out) begin
            wq_b.push_back(bus_b.win_out);
            fq_b.push_back(bus_b.frame_done);
`ifdef CONV_WINDOW_POS_EN
            colq_b.push_back(int'(bus_b.win_col));
            rowq_b.push_back(int'(bus_b.win_row));
`endif
        end
    end

    task automatic drive_a(input logic v, input logic [DW-1:0] d);
        bus_a.valid_in = v;
        bus_a.data_in  = d;
        @(negedge clk);
    endtask

    task automatic clear_a();
        wq_a.delete();
        fq_a.delete();
        vc_a.delete();
    endtask

    task automatic check_frame4(input string tag, input int unsigned base, input int unsigned v0);
        logic [WW-1:0] gw;
        logic          gf;
        for (int k = 0; k < 4; k++) begin
            gw = (base + k < wq_a.size()) ? wq_a[base+k] : '1;
            gf = (base + k < fq_a.size()) ? fq_a[base+k] : 1'bx;
            check_val($sformatf("%s_win%0d", tag, k), gw, model_win(v0, 4, k / 2, k % 2));
            check_val($sformatf("%s_fd%0d", tag, k), gf, (k == 3));
        end
    endtask

    task automatic check_single(input string tag, input int unsigned drv10);
        check_val({tag, "_count"}, wq_a.size(), 4);
        if (wq_a.size() == 4) begin
            check_val({tag, "_first"}, wq_a[0], pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));
            check_val({tag, "_last"}, wq_a[3], pack9(5, 6, 7, 9, 10, 11, 13, 14, 15));
            check_val({tag, "_latency"}, vc_a[0], drv10 + 1);
        end
        check_frame4(tag, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned drv10;
        int unsigned nfd;
        reset = 1'b1;
        bus_a.valid_in = 1'b0;
        bus_a.data_in  = '0;
        bus_b.valid_in = 1'b0;
        bus_b.data_in  = '0;
        repeat (3) @(negedge clk);
        check_val("rst_win_out", bus_a.win_out, 0);
        check_val("rst_valid_out", bus_a.valid_out, 0);
        check_val("rst_frame_done", bus_a.frame_done, 0);
        check_val("rst_b_valid_out", bus_b.valid_out, 0);
        reset = 1'b0;

        // Single 4x4 frame, back-to-back pixels.
        clear_a();
        drv10 = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 10) drv10 = cyc;
            drive_a(1'b1, DW'(i));
        end
        bus_a.valid_in = 1'b0;
        repeat (3) @(negedge clk);
        check_single("single", drv10);

        // Same frame with a bubble after every pixel.
        clear_a();
        bubble_mode = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive_a(1'b1, DW'(i));
            drive_a(1'b0, 32'hDEAD_BEEF);
        end
        repeat (3) @(negedge clk);
        bubble_mode = 1'b0;
        check_val("bubble_count", wq_a.size(), 4);
        check_frame4("bubble", 0, 0);

        // Two frames with no gap.
        clear_a();
        for (int i = 0; i < 16; i++) drive_a(1'b1, DW'(i));
        for (int i = 0; i < 16; i++) drive_a(1'b1, DW'(100 + i));
        bus_a.valid_in = 1'b0;
        repeat (3) @(negedge clk);
        check_val("b2b_count", wq_a.size(), 8);
        check_frame4("b2b_f0", 0, 0);
        check_frame4("b2b_f1", 4, 100);
        if (wq_a.size() > 4)
            check_val("b2b_f1_first", wq_a[4], pack9(100, 101, 102, 104, 105, 106, 108, 109, 110));
        nfd = 0;
        foreach (fq_a[k]) nfd += fq_a[k];
        check_val("b2b_fd_total", nfd, 2);

        // Reset after pixel 7 with valid_in still high, then a fresh frame.
        clear_a();
        for (int i = 0; i < 8; i++) drive_a(1'b1, DW'(i));
        reset = 1'b1;
        bus_a.data_in = 32'd77;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_val("rst_mid_valid_out", bus_a.valid_out, 0);
            check_val("rst_mid_frame_done", bus_a.frame_done, 0);
        end
        reset = 1'b0;
        clear_a();
        for (int i = 0; i < 16; i++) begin
            if (i == 10) drv10 = cyc;
            drive_a(1'b1, DW'(i));
        end
        bus_a.valid_in = 1'b0;
        repeat (3) @(negedge clk);
        check_single("after_rst", drv10);

        // Default 32x32 ramp frame.
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 32; c++) begin
                bus_b.valid_in = 1'b1;
                bus_b.data_in  = DW'(r * 32 + c);
                @(negedge clk);
            end
        end
        bus_b.valid_in = 1'b0;
        repeat (3) @(negedge clk);
        check_val("ramp_count", wq_b.size(), 900);
        if (wq_b.size() == 900) begin
            for (int k = 0; k < 900; k++) begin
                check_val($sformatf("ramp_win%0d", k), wq_b[k], model_win(0, 32, k / 30, k % 30));
`ifdef CONV_WINDOW_POS_EN
                check_val($sformatf("ramp_col%0d", k), colq_b[k], k % 30);
                check_val($sformatf("ramp_row%0d", k), rowq_b[k], k / 30);
`endif
            end
            check_val("ramp_last_fd", fq_b[899], 1);
        end
        nfd = 0;
        foreach (fq_b[k]) nfd += fq_b[k];
        check_val("ramp_fd_total", nfd, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
